mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Parametrised multi-cycle multiply / multiply-accumulate / divide unit for the execute stage. It replaces the inline two-cycle MADD/MSUB path and the fixed 32-bit divider with one iterative engine that serves MULT/MULTU, MADD/MADDU, MSUB/MSUBU and DIV/DIVU at any `WIDTH`. It adds annulment on flush, a divide-by-zero flag and deterministic divide-by-zero results. EX drives `start_i` and holds its stall request until `ready_o`.

## Interface
Parameters:
- WIDTH, 32, operand width; `result_o` is 2·WIDTH
- CNT_W, $clog2(WIDTH), iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_i  in  1  request; held high by EX until `ready_o` is seen
- op_i  in  3  operation code (MDU_OP_*), sampled on accept
- op1_i  in  WIDTH  rs: multiplicand or dividend, sampled on accept
- op2_i  in  WIDTH  rt: multiplier or divisor, sampled on accept
- hilo_i  in  2·WIDTH  current {hi,lo}, sampled in ACC state
- annul_i  in  1  flush; cancels any in-flight operation
- busy_o  out  1  high in every state except IDLE
- ready_o  out  1  high in DONE
- result_o  out  2·WIDTH  {hi,lo}; for divide, hi = remainder and lo = quotient
- div_by_zero_o  out  1  valid with `ready_o`

## Operation
- States: IDLE, ITER, SIGN, ACC, DONE.
- **IDLE**
  - `start_i & !annul_i` accepts the request.
  - The unit latches op, |op1| and |op2| (absolute value only for signed ops) and the two sign bits, and clears the counter.
  - Divide with `op2_i == 0`: go directly to DONE with `result_o = {op1_i, all-ones}` and `div_by_zero_o = 1`.
  - Otherwise go to ITER.
- **ITER**: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add, producing an unsigned 2·WIDTH product.
  - Divide: restoring division on a (WIDTH+1)-bit partial remainder.
  - The counter runs 0..WIDTH-1. Leave ITER when the counter equals WIDTH-1.
- **SIGN**: one cycle.
  - Signed multiply: negate the product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - MADD/MSUB family goes to ACC; all other ops go to DONE.
- **ACC**: one cycle. Compute `hilo_i + product` (MADD/MADDU) or `hilo_i − product` (MSUB/MSUBU), modulo 2^(2·WIDTH). Go to DONE.
- **DONE**
  - `ready_o = 1`; `result_o` is stable.
  - Return to IDLE on the first cycle `start_i == 0`.
  - A new request is not accepted in the same cycle as DONE→IDLE.
- **Cancellation**: `annul_i = 1`, or `start_i = 0`, in ITER, SIGN or ACC causes the next state to be IDLE. In that case:
  - `ready_o` is never raised;
  - `result_o` and `div_by_zero_o` are cleared.
- **Overflow**: signed MIN / −1 needs no special case; it yields quotient = MIN and remainder = 0.
- **Reset**: `rst` has priority over everything, including mid-operation. It forces state to IDLE and all outputs to 0: `busy_o`, `ready_o`, `result_o`, `div_by_zero_o`.

## Timing
- The accept edge is edge 0.
- Latency to the first cycle with `ready_o = 1`:
  - MULT/MULTU/DIV/DIVU: WIDTH+2 cycles.
  - MADD/MSUB family: WIDTH+3 cycles.
  - Divide by zero: 1 cycle.
- `busy_o` rises in the cycle after the accept edge.
- `hilo_i` is sampled at the ACC edge, so HI/LO forwarding from older instructions settles while the unit is busy.
- `ready_o` is registered with no combinational path from inputs.
- The cycle after DONE→IDLE has `ready_o = 0` and `busy_o = 0`.

## Structure
- Shared defines/package:
  - MDU_OP_MULT, MULTU, MADD, MADDU, MSUB, MSUBU, DIV, DIVU (3-bit codes);
  - state encodings;
  - `MduStart` / `MduStop` and `MduReady` / `MduNotReady` constants alongside the existing Div* constants.
- One sub-module, `mdu_negate`: a parametrised combinational two's-complement helper, reused for operand abs and result sign fix.
- The EX stage maps its aluop to `op_i`. EX drops its own MADD/MSUB counter and `hilo_temp` path.

## Test plan
All scenarios use WIDTH = 32.
- MULT op1 = 0xFFFFFFFD (−3), op2 = 5 -> after 34 cycles `ready_o = 1`, `result_o = 0xFFFFFFFF_FFFFFFF1`.
- DIV op1 = 7, op2 = 0xFFFFFFFE (−2) -> after 34 cycles, hi = 0x00000001, lo = 0xFFFFFFFD; then deassert `start_i` -> IDLE next cycle.
- DIVU op1 = 0x10, op2 = 0 -> `ready_o` in 1 cycle, hi = 0x10, lo = 0xFFFFFFFF, `div_by_zero_o = 1`.
- MSUB op1 = 3, op2 = 4, `hilo_i = 0x0000_0000_0000_0064` -> after 35 cycles `result_o = 0x58`.
- DIV op1 = 0x80000000, op2 = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- DIVU with `annul_i` pulsed at ITER cycle 10 -> `busy_o = 0` next cycle, `ready_o` never rises; an immediate new MULTU 2×3 completes normally with result 6. Repeat with `rst` mid-ITER -> all outputs 0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared op codes, FSM state encoding and handshake constants for the
// iterative multiply / multiply-accumulate / divide unit.
package mul_div_unit_pkg;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_MADD  = 3'd2;
  localparam logic [2:0] MDU_OP_MADDU = 3'd3;
  localparam logic [2:0] MDU_OP_MSUB  = 3'd4;
  localparam logic [2:0] MDU_OP_MSUBU = 3'd5;
  localparam logic [2:0] MDU_OP_DIV   = 3'd6;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd7;

  typedef enum logic [2:0] {
    MDU_IDLE = 3'd0,
    MDU_ITER = 3'd1,
    MDU_SIGN = 3'd2,
    MDU_ACC  = 3'd3,
    MDU_DONE = 3'd4
  } mdu_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic MduStart          = 1'b1;
  localparam logic MduStop           = 1'b0;
  localparam logic MduReady          = 1'b1;
  localparam logic MduNotReady       = 1'b0;

  function automatic logic op_is_signed(input logic [2:0] op);
    return op inside {MDU_OP_MULT, MDU_OP_MADD, MDU_OP_MSUB, MDU_OP_DIV};
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return op inside {MDU_OP_DIV, MDU_OP_DIVU};
  endfunction

  function automatic logic op_is_macc(input logic [2:0] op);
    return op inside {MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU};
  endfunction

  function automatic logic op_is_sub(input logic [2:0] op);
    return op inside {MDU_OP_MSUB, MDU_OP_MSUBU};
  endfunction

endpackage

// File: rtl/mul_div_unit_negate.sv
// Parametrised two's-complement negator, shared by operand abs and result sign fix.
module mdu_negate #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = (~a) + W'(1);

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MADD/MSUB/DIV engine: one operand bit per cycle, then sign fix
// and optional HI/LO accumulate; flush or dropped start cancels in flight.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [2:0]           op_i,
  input  logic [WIDTH-1:0]     op1_i,
  input  logic [WIDTH-1:0]     op2_i,
  input  logic [2*WIDTH-1:0]   hilo_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  mdu_state_e         state;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q;
  logic               s1_q, s2_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [WIDTH-1:0]   neg_a_in, neg_b_in, neg_a, neg_b, abs1, abs2;
  logic [2*WIDTH-1:0] neg_p;
  logic               op1_neg, op2_neg;

  // In IDLE the W-wide negators take the operands; afterwards quotient/remainder.
  assign neg_a_in = (state == MDU_IDLE) ? op1_i : lo_q;
  assign neg_b_in = (state == MDU_IDLE) ? op2_i : hi_q;

  mdu_negate #(.W(WIDTH))   u_neg_a (.a(neg_a_in),     .y(neg_a));
  mdu_negate #(.W(WIDTH))   u_neg_b (.a(neg_b_in),     .y(neg_b));
  mdu_negate #(.W(2*WIDTH)) u_neg_p (.a({hi_q, lo_q}), .y(neg_p));

  assign op1_neg = op_is_signed(op_i) && op1_i[WIDTH-1];
  assign op2_neg = op_is_signed(op_i) && op2_i[WIDTH-1];
  assign abs1    = op1_neg ? neg_a : op1_i;
  assign abs2    = op2_neg ? neg_b : op2_i;

  logic [WIDTH:0]     mul_sum, rem_shift;
  logic               rem_ge;
  logic [2*WIDTH-1:0] mul_next, div_next, fixed, acc_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : '0)};
    mul_next  = {mul_sum, lo_q[WIDTH-1:1]};
    rem_shift = {hi_q, lo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, b_q};
    div_next  = {(rem_ge ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0]),
                 lo_q[WIDTH-2:0], rem_ge};
    if (op_is_div(op_q)) begin
      // Quotient sign from operand signs; remainder follows the dividend.
      fixed = {(s1_q ? neg_b : hi_q), ((s1_q ^ s2_q) ? neg_a : lo_q)};
    end else begin
      fixed = (s1_q ^ s2_q) ? neg_p : {hi_q, lo_q};
    end
    acc_res = op_is_sub(op_q) ? (hilo_i - {hi_q, lo_q}) : (hilo_i + {hi_q, lo_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MDU_IDLE;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      cnt_q         <= '0;
      busy_o        <= 1'b0;
      ready_o       <= MduNotReady;
      result_o      <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          ready_o <= MduNotReady;
          if (start_i == MduStart && !annul_i) begin
            op_q          <= op_i;
            s1_q          <= op1_neg;
            s2_q          <= op2_neg;
            a_q           <= abs1;
            b_q           <= abs2;
            cnt_q         <= '0;
            busy_o        <= 1'b1;
            hi_q          <= '0;
            lo_q          <= op_is_div(op_i) ? abs1 : abs2;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
            if (op_is_div(op_i) && op2_i == '0) begin
              result_o      <= {op1_i, {WIDTH{1'b1}}};
              div_by_zero_o <= 1'b1;
              ready_o       <= MduReady;
              state         <= MDU_DONE;
            end else begin
              state <= MDU_ITER;
            end
          end
        end
        MDU_ITER, MDU_SIGN, MDU_ACC: begin
          if (annul_i || start_i == MduStop) begin
            state         <= MDU_IDLE;
            busy_o        <= 1'b0;
            result_o      <= '0;
            div_by_zero_o <= 1'b0;
          end else if (state == MDU_ITER) begin
            {hi_q, lo_q} <= op_is_div(op_q) ? div_next : mul_next;
            cnt_q        <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state <= MDU_SIGN;
          end else if (state == MDU_SIGN) begin
            {hi_q, lo_q} <= fixed;
            if (op_is_macc(op_q)) begin
              state <= MDU_ACC;
            end else begin
              result_o <= fixed;
              ready_o  <= MduReady;
              state    <= MDU_DONE;
            end
          end else begin
            result_o <= acc_res;
            ready_o  <= MduReady;
            state    <= MDU_DONE;
          end
        end
        MDU_DONE: begin
          if (start_i == MduStop) begin
            state   <= MDU_IDLE;
            busy_o  <= 1'b0;
            ready_o <= MduNotReady;
          end
        end
        default: state <= MDU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: latency, results, divide-by-zero,
// accumulate, overflow, annul and reset cancellation.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [W-1:0]  op1, op2;
  logic [2*W-1:0] hilo;
  logic          annul;
  logic          busy, ready, dbz;
  logic [2*W-1:0] result;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .op1_i(op1), .op2_i(op2),
    .hilo_i(hilo), .annul_i(annul), .busy_o(busy), .ready_o(ready),
    .result_o(result), .div_by_zero_o(dbz)
  );

  always #5 clk = ~clk;

  // Drives a request and returns just after the accept edge (edge 0).
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b;
    @(posedge clk);
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; op1 = '0; op2 = '0; hilo = '0; annul = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, ready, dbz, result} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b ready=%b dbz=%b result=%h, want all 0",
               busy, ready, dbz, result);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_mult();
    issue(MDU_OP_MULT, 32'hFFFF_FFFD, 32'd5);
    #1;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++; $display("FAIL mult_busy_rise: got %b want 1", busy);
    end
    repeat (W) @(posedge clk);
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL mult_ready_early: got %b want 0", ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      miscompares++;
      $display("FAIL mult_result: got ready=%b result=%h want 1 FFFFFFFFFFFFFFF1", ready, result);
    end
    release_start();
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL mult_release: got ready=%b busy=%b want 0 0", ready, busy);
    end
  endtask

  task automatic test_div_signed();
    issue(MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE);
    repeat (W) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL div_ready_early: got %b want 0", ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h0000_0001_FFFF_FFFD || dbz !== 1'b0) begin
      miscompares++;
      $display("FAIL div_7_m2: got ready=%b dbz=%b result=%h want 1 0 00000001FFFFFFFD",
               ready, dbz, result);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h0000_0001_FFFF_FFFD) begin
      miscompares++; $display("FAIL div_hold: got ready=%b result=%h want 1 stable", ready, result);
    end
    release_start();
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL div_to_idle: got ready=%b busy=%b want 0 0", ready, busy);
    end
    // Negative dividend: remainder carries the dividend's sign.
    issue(MDU_OP_DIV, 32'hFFFF_FFF9, 32'd2);
    repeat (W + 1) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      miscompares++;
      $display("FAIL div_m7_2: got ready=%b result=%h want 1 FFFFFFFFFFFFFFFD", ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_divu();
    issue(MDU_OP_DIVU, 32'hFFFF_FFFF, 32'h10);
    repeat (W + 1) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h0000_000F_0FFF_FFFF) begin
      miscompares++;
      $display("FAIL divu_max: got ready=%b result=%h want 1 0000000F0FFFFFFF", ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_div_by_zero();
    issue(MDU_OP_DIVU, 32'h10, 32'h0);
    #1;
    vectors++;
    if (ready !== 1'b1 || dbz !== 1'b1 || busy !== 1'b1 || result !== 64'h0000_0010_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL div_by_zero: got ready=%b dbz=%b busy=%b result=%h want 1 1 1 00000010FFFFFFFF",
               ready, dbz, busy, result);
    end
    release_start();
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL dbz_to_idle: got ready=%b busy=%b want 0 0", ready, busy);
    end
  endtask

  task automatic test_msub();
    hilo = '0;
    issue(MDU_OP_MSUB, 32'd3, 32'd4);
    repeat (5) @(posedge clk);
    @(negedge clk); hilo = 64'h64;
    repeat (W - 5) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL msub_ready_early: got %b want 0", ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++; $display("FAIL msub_ready_at_acc: got %b want 0", ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h58) begin
      miscompares++; $display("FAIL msub_result: got ready=%b result=%h want 1 58", ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_maddu_wrap();
    hilo = 64'h0000_0001_FFFF_FFFF;
    issue(MDU_OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (W + 2) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h0) begin
      miscompares++; $display("FAIL maddu_wrap: got ready=%b result=%h want 1 0", ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_div_overflow();
    issue(MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (W + 1) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b1 || result !== 64'h0000_0000_8000_0000) begin
      miscompares++;
      $display("FAIL div_min_m1: got ready=%b result=%h want 1 0000000080000000", ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_annul();
    bit saw_ready;
    saw_ready = 1'b0;
    issue(MDU_OP_DIVU, 32'd100, 32'd7);
    repeat (10) begin
      @(posedge clk); #1;
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== '0 || dbz !== 1'b0) begin
      miscompares++;
      $display("FAIL annul_cancel: got busy=%b ready=%b dbz=%b result=%h want 0 0 0 0",
               busy, ready, dbz, result);
    end
    @(negedge clk);
    annul = 1'b0; op = MDU_OP_MULTU; op1 = 32'd2; op2 = 32'd3;
    @(posedge clk);
    repeat (W + 1) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (saw_ready !== 1'b0 || ready !== 1'b1 || result !== 64'd6) begin
      miscompares++;
      $display("FAIL annul_then_multu: got early_ready=%b ready=%b result=%h want 0 1 6",
               saw_ready, ready, result);
    end
    release_start();
    @(posedge clk);
  endtask

  task automatic test_start_drop();
    issue(MDU_OP_MULTU, 32'd9, 32'd9);
    repeat (4) @(posedge clk);
    release_start();
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== '0) begin
      miscompares++;
      $display("FAIL start_drop: got busy=%b ready=%b result=%h want 0 0 0", busy, ready, result);
    end
  endtask

  task automatic test_rst_mid();
    issue(MDU_OP_DIVU, 32'h10, 32'h0);
    release_start();
    @(posedge clk);
    issue(MDU_OP_MULT, 32'd1234, 32'd5678);
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, ready, dbz, result} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_iter: got busy=%b ready=%b dbz=%b result=%h want all 0",
               busy, ready, dbz, result);
    end
    @(negedge clk); rst = 1'b0; start = 1'b0;
    repeat (W + 3) @(posedge clk); #1;
    vectors++;
    if (ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_stays_idle: got ready=%b busy=%b want 0 0", ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div_signed();
    test_divu();
    test_div_by_zero();
    test_msub();
    test_maddu_wrap();
    test_div_overflow();
    test_annul();
    test_start_drop();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
